// File: rtl/parking_gate_driver.sv
// Barrier gate actuator: drives the motor from the entrance controller's
// open/close commands, tracks barrier position with a travel counter, runs an
// auto-close hold timer, reverses on obstruction and pulses when a car clears.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// CLOSED    | barrier down, motor off, waiting for doorOpen
// OPENING   | motor up, position counts toward TRAVEL_TICKS
// OPEN_HOLD | barrier up, hold timer counts down to auto-close
// CLOSING   | motor down, position counts toward 0; obstruction reverses
module parking_gate_driver #(
    parameter int TRAVEL_TICKS = 8,
    parameter int HOLD_TICKS   = 20,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             doorOpen,
    input  logic             doorClose,
    input  logic             carPassSen,
    output logic             motorUp,
    output logic             motorDown,
    output logic             doorMaxOpen,
    output logic             doorMaxClose,
    output logic [CNT_W-1:0] position,
    output logic             busy,
    output logic             carPassed
);

    typedef enum logic [1:0] {
        CLOSED    = 2'd0,
        OPENING   = 2'd1,
        OPEN_HOLD = 2'd2,
        CLOSING   = 2'd3
    } gateState_t;

    localparam logic [CNT_W-1:0] TRAVEL     = CNT_W'(TRAVEL_TICKS);
    localparam logic [CNT_W-1:0] TRAVEL_M1  = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD       = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    gateState_t       state;
    logic [CNT_W-1:0] holdCnt;
    logic             senReg;
    logic             carPassedReg;

    // Gate sequencing, travel/hold counters and the car-cleared pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= CLOSED;
            position     <= '0;
            holdCnt      <= '0;
            senReg       <= 1'b0;
            carPassedReg <= 1'b0;
        end else begin
            senReg       <= carPassSen;
            carPassedReg <= (state == OPEN_HOLD) && senReg && !carPassSen;
            case (state)
                CLOSED: begin
                    if (doorOpen) begin
                        state <= OPENING;
                    end
                end
                OPENING: begin
                    // A reversal right at full travel lands here with position
                    // already at TRAVEL; clamp instead of stepping past it.
                    if (position >= TRAVEL_M1) begin
                        position <= TRAVEL;
                        holdCnt  <= HOLD;
                        state    <= OPEN_HOLD;
                    end else begin
                        position <= position + ONE;
                    end
                end
                OPEN_HOLD: begin
                    if (carPassSen || doorOpen) begin
                        holdCnt <= HOLD;
                    end else if (doorClose || holdCnt == ONE) begin
                        holdCnt <= '0;
                        state   <= CLOSING;
                    end else begin
                        holdCnt <= holdCnt - ONE;
                    end
                end
                CLOSING: begin
                    if (carPassSen || doorOpen) begin
                        state <= OPENING;
                    end else if (position <= ONE) begin
                        position <= '0;
                        state    <= CLOSED;
                    end else begin
                        position <= position - ONE;
                    end
                end
                default: begin
                    state <= CLOSED;
                end
            endcase
        end
    end

    assign motorUp      = (state == OPENING);
    assign motorDown    = (state == CLOSING);
    assign busy         = (state == OPENING) || (state == CLOSING);
    assign doorMaxOpen  = (position == TRAVEL);
    assign doorMaxClose = (position == '0);
    assign carPassed    = carPassedReg;

endmodule

// File: tb/tb_parking_gate_driver.sv
// Directed bench for parking_gate_driver: a table of per-edge vectors with
// hand-computed expected outputs, plus a timed open-latency sequence.
module tb_parking_gate_driver;

    localparam int TRAVEL = 8;
    localparam int HOLD   = 20;

    logic       clk;
    logic       rst_n;
    logic       doorOpen;
    logic       doorClose;
    logic       carPassSen;
    logic       motorUp;
    logic       motorDown;
    logic       doorMaxOpen;
    logic       doorMaxClose;
    logic [7:0] position;
    logic       busy;
    logic       carPassed;

    parking_gate_driver #(
        .TRAVEL_TICKS(TRAVEL),
        .HOLD_TICKS  (HOLD),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .doorOpen    (doorOpen),
        .doorClose   (doorClose),
        .carPassSen  (carPassSen),
        .motorUp     (motorUp),
        .motorDown   (motorDown),
        .doorMaxOpen (doorMaxOpen),
        .doorMaxClose(doorMaxClose),
        .position    (position),
        .busy        (busy),
        .carPassed   (carPassed)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstN;
        logic       op;
        logic       cl;
        logic       sen;
        logic [7:0] pos;
        logic       mu;
        logic       md;
        logic       cp;
    } vec_t;

    vec_t vecs[$];
    int   nVec = 0;
    int   nMis = 0;

    function automatic void add(input logic rstN, input logic op, input logic cl,
                                input logic sen, input int pos, input logic mu,
                                input logic md, input logic cp);
        vec_t v;
        v.rstN = rstN; v.op = op; v.cl = cl; v.sen = sen;
        v.pos  = 8'(pos); v.mu = mu; v.md = md; v.cp = cp;
        vecs.push_back(v);
    endfunction

    // Idle edge helper: no commands, no sensor.
    function automatic void idle(input int pos, input logic mu, input logic md,
                                 input logic cp);
        add(1, 0, 0, 0, pos, mu, md, cp);
    endfunction

    task automatic applyVec(input int idx, input vec_t v);
        logic [5:0] expFlags;
        logic [5:0] gotFlags;
        rst_n      = v.rstN;
        doorOpen   = v.op;
        doorClose  = v.cl;
        carPassSen = v.sen;
        @(posedge clk);
        #1;
        expFlags = {v.mu, v.md, (v.pos == 8'(TRAVEL)), (v.pos == 8'd0), v.mu | v.md, v.cp};
        gotFlags = {motorUp, motorDown, doorMaxOpen, doorMaxClose, busy, carPassed};
        nVec++;
        if (gotFlags !== expFlags || position !== v.pos) begin
            nMis++;
            $display("FAIL vec%0d: got up/dn/maxO/maxC/busy/cp=%b pos=%0d, want %b pos=%0d",
                     idx, gotFlags, position, expFlags, v.pos);
        end
    endtask

    initial begin
        int edges;
        rst_n = 0; doorOpen = 0; doorClose = 0; carPassSen = 0;

        // Reset held two cycles, then one idle cycle in CLOSED.
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0);

        // One-cycle open pulse, full travel, 20-cycle hold, auto-close.
        add(1, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i < TRAVEL; i++) idle(i, 1, 0, 0);
        idle(TRAVEL, 0, 0, 0);
        for (int i = 1; i < HOLD; i++) idle(TRAVEL, 0, 0, 0);
        idle(TRAVEL, 0, 1, 0);
        for (int i = TRAVEL - 1; i >= 1; i--) idle(i, 0, 1, 0);
        idle(0, 0, 0, 0);

        // Reopen; car under beam 5 cycles, pulse on clear, hold restarts.
        add(1, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i < TRAVEL; i++) idle(i, 1, 0, 0);
        idle(TRAVEL, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 1, TRAVEL, 0, 0, 0);
        idle(TRAVEL, 0, 0, 1);
        for (int i = 0; i < HOLD - 2; i++) idle(TRAVEL, 0, 0, 0);
        idle(TRAVEL, 0, 1, 0);
        idle(7, 0, 1, 0);
        idle(6, 0, 1, 0);
        idle(5, 0, 1, 0);

        // Obstruction at position 5 while closing: reverse without decrement.
        add(1, 0, 0, 1, 5, 1, 0, 0);
        idle(6, 1, 0, 0);
        idle(7, 1, 0, 0);
        idle(TRAVEL, 0, 0, 0);

        // Open+close together reloads hold; close refused with car present.
        for (int i = 0; i < 3; i++) idle(TRAVEL, 0, 0, 0);
        add(1, 1, 1, 0, TRAVEL, 0, 0, 0);
        for (int i = 0; i < HOLD - 1; i++) idle(TRAVEL, 0, 0, 0);
        add(1, 0, 1, 1, TRAVEL, 0, 0, 0);
        idle(TRAVEL, 0, 0, 1);
        add(1, 0, 1, 0, TRAVEL, 0, 1, 0);
        for (int i = 7; i >= 4; i--) idle(i, 0, 1, 0);

        // doorOpen reverses at position 4, then reset mid-opening.
        add(1, 1, 0, 0, 4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) applyVec(i, vecs[i]);

        // Open latency: doorMaxOpen must appear on the 9th edge counting the
        // edge that samples doorOpen.
        rst_n = 1; doorOpen = 1; doorClose = 0; carPassSen = 0;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            doorOpen = 0;
            edges++;
        end while (!doorMaxOpen && edges < 40);
        nVec++;
        if (edges != TRAVEL + 1) begin
            nMis++;
            $display("FAIL openLatency: got %0d edges to doorMaxOpen, want %0d",
                     edges, TRAVEL + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/parking_gate_driver.md
Name: parking_gate_driver

Overview:
Gate actuator stage directly downstream of the parking entrance controller. Consumes its doorOpen/doorClose commands, drives the barrier motor, and tracks barrier position with a travel counter. Produces the doorMaxOpen/doorMaxClose limit signals that the controller consumes. Adds an auto-close hold timer, obstruction reversal, and a car-passed pulse for occupancy counting.

Parameters:
TRAVEL_TICKS, 8, clock cycles for full travel between closed and open (>=1)
HOLD_TICKS, 20, cycles the gate stays open with no car under it before auto-close (>=1)
CNT_W, 8, width of position and hold counters; TRAVEL_TICKS and HOLD_TICKS must fit

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
doorOpen  input  1  open command from entrance controller, level
doorClose  input  1  close command from entrance controller, level
carPassSen  input  1  beam sensor under barrier, 1 = car/obstruction present
motorUp  output  1  drive barrier toward open
motorDown  output  1  drive barrier toward closed
doorMaxOpen  output  1  barrier fully open (position == TRAVEL_TICKS)
doorMaxClose  output  1  barrier fully closed (position == 0)
position  output  CNT_W  current barrier position, 0 = closed
busy  output  1  motor moving (OPENING or CLOSING)
carPassed  output  1  one-cycle pulse when a car clears the beam while open

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge), at any time including mid-travel: state CLOSED, position 0, hold 0, sensor register 0. Outputs: motorUp=0, motorDown=0, doorMaxClose=1, doorMaxOpen=0, busy=0, carPassed=0.
- All outputs are decoded from registered state only, with no input-to-output combinational path:
  - motorUp = OPENING; motorDown = CLOSING; busy = OPENING|CLOSING.
  - doorMaxOpen = (position==TRAVEL_TICKS); doorMaxClose = (position==0).
- FSM states: CLOSED, OPENING, OPEN_HOLD, CLOSING.
- CLOSED:
  - doorOpen=1 -> OPENING.
  - doorClose alone is ignored.
- OPENING:
  - Each edge: position+1.
  - When the new value == TRAVEL_TICKS: go to OPEN_HOLD and load hold=HOLD_TICKS.
  - doorClose and carPassSen are ignored; opening always completes.
  - Latency: doorOpen sampled at edge E0 gives motorUp high for exactly TRAVEL_TICKS cycles; doorMaxOpen rises after edge E0+TRAVEL_TICKS.
- OPEN_HOLD (position stays at TRAVEL_TICKS):
  - carPassSen=1 or doorOpen=1: reload hold=HOLD_TICKS.
  - Otherwise decrement hold.
  - -> CLOSING when carPassSen=0 and doorOpen=0 and (hold==1 before decrement, or doorClose=1).
  - Early close via doorClose is refused while carPassSen=1.
- CLOSING:
  - carPassSen=1 or doorOpen=1 -> OPENING at that edge. Position is not decremented on the reversal edge; opening resumes from the current position.
  - Otherwise position-1; new value 0 -> CLOSED.
- Priority on simultaneous inputs: reset > carPassSen/doorOpen > doorClose > timer.
- carPassed:
  - carPassSen is registered once.
  - carPassed pulses for 1 cycle when the registered value is 1, the current value is 0, and state is OPEN_HOLD.
  - No pulse from falling edges in other states.
- Position never wraps: it is clamped to the range 0..TRAVEL_TICKS by construction.
- Counter arithmetic is unsigned CNT_W bits.

Test Plan:
1. Reset then idle, TRAVEL_TICKS=8, HOLD_TICKS=20, rst_n=0 for 2 cycles -> doorMaxClose=1, doorMaxOpen=0, position=0, motors 0, busy=0.
2. doorOpen=1 for 1 cycle from CLOSED -> motorUp high exactly 8 cycles; position steps 1..8; doorMaxOpen=1 after the 9th edge. With no further input, gate holds 20 cycles, then motorDown for 8 cycles, then doorMaxClose=1.
3. carPassSen high for 5 cycles during OPEN_HOLD, then low -> carPassed pulses once on the falling edge; hold reloads and auto-close starts 20 cycles after carPassSen falls.
4. carPassSen=1 while CLOSING at position 5 -> next edge state OPENING with position 5 (no decrement); position reaches 8 after 3 more edges; doorMaxOpen=1.
5. In OPEN_HOLD: doorClose=1 with carPassSen=1 -> stays open. doorClose=1 with carPassSen=0 -> CLOSING next edge. doorOpen=doorClose=1 together -> stays open with hold reloaded.
6. rst_n=0 mid-OPENING at position 4 -> after that edge position=0, CLOSED, motorUp=0, doorMaxClose=1. doorClose=1 in CLOSED -> no motion.
